mem_access_seq: RTL

- Sequences data-memory accesses for LC-3 load/store instructions: LD, LDR, LDI, ST, STR, STI.
- Sits between the execute stage and the combinational memory-access stage.
- Drives that stage's mem_state, M_Control, M_Addr and M_Data for exactly as many cycles as each access needs.
- Captures memout into a load-data register and stalls the pipeline while an access is in flight.

---
 rtl/mem_access_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences LC-3 data-memory accesses (LD/LDR/LDI/ST/STR/STI)
// between the execute stage and the combinational memory-access stage.
//
// Ports:
//   clock, reset     rising-edge clock, async active-low reset
//   start            execute presents a memory instruction (sampled in IDLE only)
//   is_store         1 = store, 0 = load
//   is_indir         1 = LDI/STI (pointer fetch phase first)
//   E_Addr, E_Data   effective address / store data from execute
//   memout           read data from the memory-access stage
//   mem_state        0 READ_MEM, 1 READ_MEM_INDIR, 2 WRITE_MEM, 3 INIT_STATE
//   M_Control        1 = use the previously read pointer as the address
//   M_Addr, M_Data   latched address / store data, stable for the instruction
//   busy             access in flight, upstream must stall
//   done             one-cycle pulse after the final phase
//   ld_data          captured load result
module mem_access_seq #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic        is_indir,
  input  logic [15:0] E_Addr,
  input  logic [15:0] E_Data,
  input  logic [15:0] memout,
  output logic [1:0]  mem_state,
  output logic        M_Control,
  output logic [15:0] M_Addr,
  output logic [15:0] M_Data,
  output logic        busy,
  output logic        done,
  output logic [15:0] ld_data
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_IND, ST_RD, ST_WR} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_store, r_indir;
  logic [15:0] r_addr, r_data, r_ld;
  logic        r_done;
  logic        w_last;
  logic [1:0]  w_mem_state;
  logic        w_busy, w_mctl;

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_next      = r_state;
    w_mem_state = 2'd3;
    w_busy      = 1'b0;
    w_mctl      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_indir)      w_next = ST_IND;
          else if (is_store) w_next = ST_WR;
          else               w_next = ST_RD;
        end
      end
      ST_IND: begin
        w_mem_state = 2'd1;
        w_busy      = 1'b1;
        if (w_last) w_next = r_store ? ST_WR : ST_RD;
      end
      ST_RD: begin
        w_mem_state = 2'd0;
        w_busy      = 1'b1;
        w_mctl      = r_indir;
        if (w_last) w_next = ST_IDLE;
      end
      ST_WR: begin
        w_mem_state = 2'd2;
        w_busy      = 1'b1;
        w_mctl      = r_indir;
        if (w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_store <= 1'b0;
      r_indir <= 1'b0;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_ld    <= 16'h0000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Phase counter restarts on every state change; parked at 0 in IDLE.
      if (w_next != r_state || r_state == ST_IDLE) r_cnt <= 4'd0;
      else                                         r_cnt <= r_cnt + 4'd1;
      // done marks the first IDLE cycle after the final (RD/WR) phase.
      r_done <= (r_state == ST_RD || r_state == ST_WR) && w_last;
      if (r_state == ST_IDLE && start) begin
        r_addr  <= E_Addr;
        r_data  <= E_Data;
        r_store <= is_store;
        r_indir <= is_indir;
      end
      if (r_state == ST_RD && w_last) r_ld <= memout;
    end
  end

  assign mem_state = w_mem_state;
  assign M_Control = w_mctl;
  assign M_Addr    = r_addr;
  assign M_Data    = r_data;
  assign busy      = w_busy;
  assign done      = r_done;
  assign ld_data   = r_ld;

endmodule
